// File: rtl/layer_sequencer.sv
// layer_sequencer: runs a layer as num_filters filter passes, each a chain of scheduler
// rounds with drain write-back. Define LAYER_SEQUENCER_PERF_EN to add the cycle_count output.
module layer_sequencer #(
  parameter int FILT_W  = 8,
  parameter int ROUND_W = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [FILT_W-1:0]  num_filters,
  output logic               busy,
  output logic               done,
  output logic               filter_load_req,
  input  logic               filter_load_ack,
  output logic               sched_rst,
  input  logic               sched_round_ready,
  input  logic               sched_done,
  output logic               sched_advance,
  output logic               drain_req,
  input  logic               drain_ack,
  output logic [FILT_W-1:0]  filter_index,
  output logic [ROUND_W-1:0] round_index
`ifdef LAYER_SEQUENCER_PERF_EN
  ,
  output logic [31:0]        cycle_count
`endif
);
  typedef enum logic [2:0] {
    IDLE, LOAD, SCHED_RST, RUN, DRAIN, ADVANCE, NEXT, FINISH
  } state_e;

  localparam logic [FILT_W-1:0]  F_ONE = 1;
  localparam logic [ROUND_W-1:0] R_ONE = 1;

  state_e             state_q, state_d;
  logic [FILT_W-1:0]  nfilt_q, nfilt_d;
  logic [FILT_W-1:0]  fidx_q, fidx_d;
  logic [ROUND_W-1:0] ridx_q, ridx_d;
  logic               last_q, last_d;
  logic               srst_cnt_q, srst_cnt_d;  // second SCHED_RST cycle marker

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      nfilt_q    <= '0;
      fidx_q     <= '0;
      ridx_q     <= '0;
      last_q     <= 1'b0;
      srst_cnt_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      nfilt_q    <= nfilt_d;
      fidx_q     <= fidx_d;
      ridx_q     <= ridx_d;
      last_q     <= last_d;
      srst_cnt_q <= srst_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    nfilt_d    = nfilt_q;
    fidx_d     = fidx_q;
    ridx_d     = ridx_q;
    last_d     = last_q;
    srst_cnt_d = srst_cnt_q;
    case (state_q)
      IDLE: if (start) begin
        nfilt_d = num_filters;
        fidx_d  = '0;
        ridx_d  = '0;
        state_d = (num_filters == '0) ? FINISH : LOAD;
      end
      LOAD: if (filter_load_ack) begin
        srst_cnt_d = 1'b0;
        state_d    = SCHED_RST;
      end
      SCHED_RST: begin
        srst_cnt_d = 1'b1;
        if (srst_cnt_q) state_d = RUN;
      end
      RUN: begin
        // sched_done wins so a coincident round_ready never triggers an advance
        if (sched_done) begin
          last_d  = 1'b1;
          state_d = DRAIN;
        end else if (sched_round_ready) begin
          last_d  = 1'b0;
          state_d = DRAIN;
        end
      end
      DRAIN: if (drain_ack) begin
        ridx_d  = ridx_q + R_ONE;
        state_d = last_q ? NEXT : ADVANCE;
      end
      ADVANCE: state_d = RUN;
      NEXT: begin
        ridx_d = '0;
        if (fidx_q + F_ONE == nfilt_q) begin
          state_d = FINISH;
        end else begin
          fidx_d  = fidx_q + F_ONE;
          state_d = LOAD;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy            = state_q inside {LOAD, SCHED_RST, RUN, DRAIN, ADVANCE, NEXT};
  assign done            = (state_q == FINISH);
  assign filter_load_req = (state_q == LOAD);
  assign drain_req       = (state_q == DRAIN);
  assign sched_advance   = (state_q == ADVANCE);
  assign sched_rst       = !(state_q inside {RUN, DRAIN, ADVANCE});
  assign filter_index    = fidx_q;
  assign round_index     = ridx_q;

`ifdef LAYER_SEQUENCER_PERF_EN
  logic        accept;
  logic [31:0] cyc_q;

  assign accept = (state_q == IDLE) && start;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        cyc_q <= '0;
    else if (accept)                 cyc_q <= '0;
    else if (busy && (cyc_q != '1))  cyc_q <= cyc_q + 32'd1;
  end

  assign cycle_count = cyc_q;
`endif
endmodule

// File: tb/tb_layer_sequencer.sv
// Randomized bench for layer_sequencer: a cycle-level host/scheduler driver plus event-count
// expectations derived from the number of passes and rounds requested.
module tb_layer_sequencer;
  localparam int FW = 8;
  localparam int RW = 12;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [FW-1:0] num_filters = '0;
  logic filter_load_ack = 1'b0, sched_round_ready = 1'b0, sched_done = 1'b0, drain_ack = 1'b0;
  logic busy, done, filter_load_req, sched_rst, sched_advance, drain_req;
  logic [FW-1:0] filter_index;
  logic [RW-1:0] round_index;
`ifdef LAYER_SEQUENCER_PERF_EN
  logic [31:0] cycle_count;
`endif

  int n_chk = 0, n_err = 0;
  int m_drain = 0, m_adv = 0, m_done = 0, m_busy = 0, m_load = 0;
  logic p_drain = 1'b0, p_load = 1'b0;

  always #5 clk = ~clk;

  layer_sequencer #(.FILT_W(FW), .ROUND_W(RW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_filters(num_filters),
    .busy(busy), .done(done),
    .filter_load_req(filter_load_req), .filter_load_ack(filter_load_ack),
    .sched_rst(sched_rst), .sched_round_ready(sched_round_ready), .sched_done(sched_done),
    .sched_advance(sched_advance), .drain_req(drain_req), .drain_ack(drain_ack),
    .filter_index(filter_index), .round_index(round_index)
`ifdef LAYER_SEQUENCER_PERF_EN
    , .cycle_count(cycle_count)
`endif
  );

  // event counters over the cycle ending at each rising edge
  always @(posedge clk) begin
    if (drain_req && !p_drain)       m_drain++;
    if (filter_load_req && !p_load)  m_load++;
    if (sched_advance)               m_adv++;
    if (done)                        m_done++;
    if (busy)                        m_busy++;
    p_drain = drain_req;
    p_load  = filter_load_req;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_load"}, 32'(filter_load_req), 0);
    chk({tag, "_drain"}, 32'(drain_req), 0);
    chk({tag, "_adv"}, 32'(sched_advance), 0);
    chk({tag, "_srst"}, 32'(sched_rst), 1);
    chk({tag, "_fidx"}, 32'(filter_index), 0);
    chk({tag, "_ridx"}, 32'(round_index), 0);
  endtask

  // Caller is at a falling edge. rpp=0 -> random rounds per pass; ld_dly<0 -> random load delay.
  task automatic run_layer(input int n, input int rpp, input int ld_dly, input bit both_last,
                           input bit abort);
    int  drains = 0, rounds, dly;
    int  b_drain = m_drain, b_adv = m_adv, b_done = m_done, b_load = m_load, b_busy = m_busy;
    bit  last;
    start = 1'b1;
    num_filters = FW'(n);
    @(negedge clk);
    start = 1'b0;
    if (n == 0) begin
      chk("zero_done", 32'(done), 1);
      chk("zero_busy", 32'(busy), 0);
      chk("zero_srst", 32'(sched_rst), 1);
      chk("zero_load", 32'(filter_load_req), 0);
      @(negedge clk);
      chk("zero_done_end", 32'(done), 0);
      chk("zero_srst_end", 32'(sched_rst), 1);
      chk("zero_loads", m_load - b_load, 0);
      chk("zero_busycyc", m_busy - b_busy, 0);
      return;
    end
    for (int p = 0; p < n; p++) begin
      rounds = (rpp > 0) ? rpp : int'($urandom_range(1, 4));
      drains += rounds;
      chk("load_req", 32'(filter_load_req), 1);
      chk("busy", 32'(busy), 1);
      chk("fidx", 32'(filter_index), p);
      dly = (ld_dly >= 0) ? ld_dly : int'($urandom_range(0, 3));
      for (int i = 0; i < dly; i++) begin
        @(negedge clk);
        chk("load_hold", 32'(filter_load_req), 1);
        chk("load_srst", 32'(sched_rst), 1);
      end
      filter_load_ack = 1'b1;
      @(negedge clk);
      filter_load_ack = 1'b0;
      chk("load_drop", 32'(filter_load_req), 0);
      chk("srst_c1", 32'(sched_rst), 1);
      @(negedge clk);
      chk("srst_c2", 32'(sched_rst), 1);
      @(negedge clk);
      chk("srst_rel", 32'(sched_rst), 0);
      for (int r = 0; r < rounds; r++) begin
        last = (r == rounds - 1);
        // stray start / acks while the scheduler runs must have no effect
        repeat ($urandom_range(0, 2)) begin
          start = 1'($urandom);
          num_filters = FW'($urandom);
          filter_load_ack = 1'($urandom);
          drain_ack = 1'($urandom);
          @(negedge clk);
          chk("run_idle", {30'b0, drain_req, sched_advance}, 0);
        end
        start = 1'b0;
        filter_load_ack = 1'b0;
        drain_ack = 1'b0;
        sched_done = last;
        sched_round_ready = !last || both_last;
        @(negedge clk);
        sched_done = 1'b0;
        sched_round_ready = 1'b0;
        chk("drain_req", 32'(drain_req), 1);
        chk("ridx", 32'(round_index), r);
        chk("fidx_run", 32'(filter_index), p);
        if (abort && p == 1 && r == 1) begin
          #2 rst = 1'b0;
          #1 chk_reset_outs("async_rst");
          return;
        end
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          chk("drain_hold", 32'(drain_req), 1);
        end
        drain_ack = 1'b1;
        @(negedge clk);
        drain_ack = 1'b0;
        chk("ridx_inc", 32'(round_index), r + 1);
        chk("drain_drop", 32'(drain_req), 0);
        if (!last) begin
          chk("adv", 32'(sched_advance), 1);
          @(negedge clk);
          chk("adv_once", 32'(sched_advance), 0);
        end else begin
          chk("no_adv_last", 32'(sched_advance), 0);
          chk("next_srst", 32'(sched_rst), 1);
          @(negedge clk);
        end
      end
    end
    chk("done", 32'(done), 1);
    chk("busy_fin", 32'(busy), 0);
    chk("fidx_fin", 32'(filter_index), n - 1);
    chk("ridx_fin", 32'(round_index), 0);
    @(negedge clk);
    chk("done_pulse", 32'(done), 0);
    chk("busy_idle", 32'(busy), 0);
    chk("fidx_hold", 32'(filter_index), n - 1);
    chk("n_drain", m_drain - b_drain, drains);
    chk("n_adv", m_adv - b_adv, drains - n);
    chk("n_load", m_load - b_load, n);
    chk("n_done", m_done - b_done, 1);
`ifdef LAYER_SEQUENCER_PERF_EN
    chk("cyc_count", cycle_count, m_busy - b_busy);
    repeat (3) @(negedge clk);
    chk("cyc_hold", cycle_count, m_busy - b_busy);
`endif
  endtask

  initial begin
    #3 chk_reset_outs("por");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;                      // start issued on the same edge as release
    run_layer(2, 4, 0, 1'b0, 1'b0);  // 2 passes x (3 ready + done)
    run_layer(0, 1, 0, 1'b0, 1'b0);  // empty layer
    run_layer(1, 2, 10, 1'b0, 1'b0); // slow filter load
    run_layer(2, 2, 0, 1'b1, 1'b0);  // done and ready together on last round
    run_layer(2, 3, 0, 1'b0, 1'b1);  // reset mid-DRAIN
    @(negedge clk);
    chk_reset_outs("in_rst");
    rst = 1'b1;
    run_layer(2, 2, -1, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++)
      run_layer(int'($urandom_range(0, 3)), 0, -1, 1'($urandom), 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/layer_sequencer.md
LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 SHALL have parameter FILT_W, default 8, width of filter-pass count and index.
REQ-002 SHALL have parameter ROUND_W, default 12, width of round index.
REQ-003 SHALL have ports: clk  in  1  sole clock, rising edge; rst  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: start  in  1  host request to run a layer; num_filters  in  FILT_W  filter passes for the layer, sampled with start.
REQ-005 SHALL have ports: busy  out  1  layer in progress; done  out  1  one-cycle end-of-layer pulse.
REQ-006 SHALL have ports: filter_load_req  out  1  load the next filter set; filter_load_ack  in  1  filter set loaded.
REQ-007 SHALL have ports: sched_rst  out  1  hold the round scheduler in reset; sched_round_ready  in  1  scheduler waiting for advance; sched_done  in  1  scheduler finished all positions.
REQ-008 SHALL have ports: sched_advance  out  1  one-cycle advance pulse to the scheduler.
REQ-009 SHALL have ports: drain_req  out  1  write back round results; drain_ack  in  1  write-back complete.
REQ-010 SHALL have ports: filter_index  out  FILT_W  current pass; round_index  out  ROUND_W  rounds completed in the current pass.

Function
REQ-011 SHALL implement the states IDLE, LOAD, SCHED_RST, RUN, DRAIN, ADVANCE, NEXT and FINISH.
REQ-012 In IDLE, start=1 with num_filters>0 SHALL latch num_filters, clear both indices, set busy next cycle and enter LOAD.
REQ-013 In IDLE, start=1 with num_filters=0 SHALL go to FINISH directly without asserting filter_load_req or releasing sched_rst.
REQ-014 start SHALL be ignored while busy=1.
REQ-015 LOAD SHALL hold filter_load_req=1 until filter_load_ack=1, then go to SCHED_RST.
REQ-016 SCHED_RST SHALL keep sched_rst=1 for exactly 2 cycles, then go to RUN.
REQ-017 sched_rst SHALL be 1 in every state except RUN, DRAIN and ADVANCE.
REQ-018 In RUN, sched_done=1 SHALL go to DRAIN with a last-round flag set.
REQ-019 In RUN, sched_round_ready=1 with sched_done=0 SHALL go to DRAIN with the last-round flag clear; sched_done has priority when both are 1.
REQ-020 DRAIN SHALL hold drain_req=1 until drain_ack=1.
REQ-021 On drain_ack in DRAIN, round_index SHALL increment (wrapping modulo 2^ROUND_W); the next state SHALL be NEXT if last-round is set, else ADVANCE.
REQ-022 ADVANCE SHALL assert sched_advance for exactly 1 cycle, then return to RUN.
REQ-023 sched_advance SHALL never be 1 outside ADVANCE.
REQ-024 NEXT SHALL clear round_index; if filter_index+1 == latched num_filters it SHALL go to FINISH, else increment filter_index and go to LOAD.
REQ-025 FINISH SHALL pulse done for 1 cycle, clear busy in the same cycle, and return to IDLE.
REQ-026 filter_index SHALL hold its final value until the next accepted start.
REQ-027 An ack arriving in any state other than the one waiting for it SHALL be ignored.
REQ-028 All outputs SHALL be registered or decoded only from state; no combinational path from inputs to outputs.

Reset
REQ-029 rst=0 SHALL asynchronously force IDLE, busy=0, done=0, filter_load_req=0, drain_req=0, sched_advance=0, sched_rst=1 and both indices to 0, including mid-layer.
REQ-030 Release of rst SHALL take effect on the next rising clk; the first start SHALL be honoured on the first edge after release.

Configuration
REQ-031 With macro LAYER_SEQUENCER_PERF_EN defined, the block SHALL add output cycle_count (32 bits): cleared on accepted start, incremented every cycle while busy=1, saturating at all-ones, held after done, and reset to 0 by rst.
REQ-032 Without LAYER_SEQUENCER_PERF_EN, cycle_count and its counter SHALL be absent and all other behaviour identical.

Verification
REQ-033 Bench SHALL check: num_filters=2, 3 round_ready pulses per pass, sched_done on the 4th round, immediate acks -> 8 drain_req, 6 sched_advance pulses, filter_index 0 then 1, a single done pulse, and busy low after done.
REQ-034 Bench SHALL check: start with num_filters=0 -> done one cycle after start, with no filter_load_req and sched_rst held 1 throughout.
REQ-035 Bench SHALL check: filter_load_ack delayed 10 cycles -> filter_load_req stable for all 10 cycles and sched_rst held 1 until 2 cycles after the ack.
REQ-036 Bench SHALL check: sched_done and sched_round_ready both 1 in the same RUN cycle -> treated as the last round, with no sched_advance issued.
REQ-037 Bench SHALL check: rst=0 while in DRAIN with drain_req=1 -> all outputs at reset values before the next clk edge, then a fresh start runs normally.
REQ-038 Bench SHALL check, with LAYER_SEQUENCER_PERF_EN: the REQ-033 run -> cycle_count equals the number of cycles busy was 1, and the value is held after done.
